// File: rtl/mem_req_adapter.sv
// Byte-addressed load/store front end for a word-indexed memory.
// One request in flight; sub-word stores are merged by read-modify-write.
module mem_req_adapter #(
  parameter int _W = 32,
  parameter int _D = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [_W-1:0]     req_wdata,
  input  logic [_W/8-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [_W-1:0]     resp_rdata,
  output logic              resp_err,
  output logic              mem_read_en,
  output logic [31:0]       mem_read_addr,
  input  logic [_W-1:0]     mem_read_data,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_addr,
  output logic [_W-1:0]     mem_write_data
);
  localparam int BW   = _W / 8;
  localparam int OFFS = $clog2(BW);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPTURE, WR_FULL, RMW_READ, RMW_WRITE, RESP
  } state_e;

  typedef struct packed {
    logic [31:0]   widx;
    logic [_W-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  state_e        state_q;
  req_t          req_q;
  logic [_W-1:0] rdata_q;
  logic          err_q;

  logic [31:0]   req_widx;
  logic [_W-1:0] merged;
  logic          rd_st, wr_st;

  assign req_widx = req_addr >> OFFS;

  // Read data for the RMW arrives in RMW_WRITE, so the merge is combinational.
  for (genvar b = 0; b < BW; b++) begin : g_merge
    assign merged[8*b +: 8] = req_q.be[b] ? req_q.wdata[8*b +: 8]
                                          : mem_read_data[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_q   <= '{widx: req_widx, wdata: req_wdata, be: req_be};
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (req_widx >= 32'(_D)) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (!req_we)   state_q <= RD_ISSUE;
          else if (&req_be)       state_q <= WR_FULL;
          else if (~|req_be)      state_q <= RESP;
          else                    state_q <= RMW_READ;
        end
        RD_ISSUE:   state_q <= RD_CAPTURE;
        RD_CAPTURE: begin
          rdata_q <= mem_read_data;
          state_q <= RESP;
        end
        WR_FULL:    state_q <= RESP;
        RMW_READ:   state_q <= RMW_WRITE;
        RMW_WRITE:  state_q <= RESP;
        RESP:       if (resp_ready) state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode from state but are masked while reset is held.
  assign rd_st = rst_n && (state_q == RD_ISSUE || state_q == RMW_READ);
  assign wr_st = rst_n && (state_q == WR_FULL  || state_q == RMW_WRITE);

  assign req_ready      = rst_n && (state_q == IDLE);
  assign resp_valid     = rst_n && (state_q == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_read_en    = rd_st;
  assign mem_read_addr  = rd_st ? req_q.widx : 32'd0;
  assign mem_write_en   = wr_st;
  assign mem_write_addr = wr_st ? req_q.widx : 32'd0;
  assign mem_write_data = !wr_st ? '0 :
                          (state_q == RMW_WRITE) ? merged : req_q.wdata;
endmodule

// File: tb/tb_mem_req_adapter.sv
// Random and directed load/store traffic against a word-array reference
// memory; latency, strobe counts and response payloads are all checked.
module tb_mem_req_adapter;
  localparam int W = 32;
  localparam int D = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr;
  logic [W-1:0]  req_wdata;
  logic [W/8-1:0] req_be;
  logic          resp_valid, resp_ready, resp_err;
  logic [W-1:0]  resp_rdata;
  logic          mem_read_en, mem_write_en;
  logic [31:0]   mem_read_addr, mem_write_addr;
  logic [W-1:0]  mem_read_data, mem_write_data;

  mem_req_adapter #(._W(W), ._D(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // Memory the DUT actually drives, plus an independent reference copy.
  logic [W-1:0] mem     [D];
  logic [W-1:0] ref_mem [D];
  int rd_cnt = 0, wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_write_addr[9:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read_en) begin
      mem_read_data <= mem[mem_read_addr[9:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int stall);
    logic [31:0] widx, exp_rd, merged;
    logic        exp_err;
    int          exp_lat, exp_nrd, exp_nwr, r0, w0, k;
    bit          got;
    widx = addr >> 2;
    exp_rd = 0; exp_err = 0; exp_nrd = 0; exp_nwr = 0; merged = 0;
    if (widx >= D) begin
      exp_err = 1; exp_lat = 1;
    end else if (!we) begin
      exp_rd = ref_mem[widx]; exp_lat = 3; exp_nrd = 1;
    end else if (be == 4'hF) begin
      merged = wd; exp_lat = 2; exp_nwr = 1;
    end else if (be == 4'h0) begin
      exp_lat = 1;
    end else begin
      for (int b = 0; b < 4; b++)
        merged[8*b +: 8] = be[b] ? wd[8*b +: 8] : ref_mem[widx][8*b +: 8];
      exp_lat = 3; exp_nrd = 1; exp_nwr = 1;
    end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    resp_ready = 0;
    r0 = rd_cnt; w0 = wr_cnt;
    k = 0; got = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        // Scramble inputs after accept; they must not matter any more.
        req_valid = 0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        if (exp_nrd > 0) begin
          chk("rd_en_t1", mem_read_en, 1);
          chk("rd_addr_t1", mem_read_addr, widx);
        end else chk("rd_addr_idle", mem_read_addr, 0);
      end
      if (resp_valid) got = 1;
    end
    chk("resp_lat", got ? k : 99, exp_lat);
    if (!got) return;
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", resp_err, exp_err);
    chk("n_reads", rd_cnt - r0, exp_nrd);
    chk("n_writes", wr_cnt - w0, exp_nwr);
    if (exp_nwr > 0) ref_mem[widx] = merged;

    for (int i = 0; i < stall; i++) begin
      req_valid = (i == 1); req_we = 0; req_addr = 32'h40;
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_ready", req_ready, 0);
    end
    req_valid = 0;
    if (stall > 0) chk("stall_no_mem", (rd_cnt - r0) + (wr_cnt - w0), exp_nrd + exp_nwr);
    resp_ready = 1;
    @(negedge clk);
    chk("post_valid", resp_valid, 0);
    chk("post_ready", req_ready, 1);
    resp_ready = 0;
  endtask

  initial begin
    logic [31:0] a, w0;
    logic [3:0]  be;
    int          sel;
    for (int i = 0; i < D; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_en", {mem_read_en, mem_write_en}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);

    do_req(0, 32'h10, 0, 4'h0, 0);
    do_req(1, 32'h20, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 32'h20, 0, 4'h0, 0);
    do_req(1, 32'h22, 32'h00AA5500, 4'h6, 0);
    do_req(0, 32'h20, 0, 4'h0, 0);
    chk("merge_const", resp_rdata, 32'hDEAA55EF);
    do_req(0, 32'h1000, 0, 4'h0, 0);
    do_req(1, 32'h20, 32'h12345678, 4'h0, 0);
    do_req(0, 32'h20, 0, 4'h0, 5);

    // Reset while the partial store sits in its read phase.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h11223344; req_be = 4'h3;
    @(negedge clk);
    req_valid = 0; rst_n = 0; w0 = wr_cnt;
    @(negedge clk);
    chk("rmw_rst_wen", mem_write_en, 0);
    chk("rmw_rst_ren", mem_read_en, 0);
    chk("rmw_rst_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rmw_rst_ready", req_ready, 1);
    chk("rmw_rst_valid2", resp_valid, 0);
    chk("rmw_rst_nowrite", wr_cnt - w0, 0);
    do_req(0, 32'h20, 0, 4'h0, 0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? ($urandom | 32'h1000) : ((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0: be = 4'hF;
        1: be = 4'h0;
        default: be = 4'($urandom);
      endcase
      do_req(1'($urandom), a, $urandom, be, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
